// File: rtl/z80_int_ctrl.sv
// z80_int_ctrl -- vectored (IM 2) interrupt controller for the Z80 bus.
//
// Latches rising edges on up to NUM_SRC peripheral request lines, picks the
// highest-priority unmasked one (index 0 highest) and drives nINT. During the
// M1+IORQ acknowledge cycle it supplies the vector {VBASE[7:4], src, 0}.
// Four I/O registers at IO_BASE+0..+3: MASK, PEND (W1C), VBASE, ISR (write = EOI).
//
// Build option: define ICTRL_NEST_EN for nested service. A pending source
// may then interrupt a lower-priority source already in service.
//
// Ports:
//   CLK, nRESET      clock (rising edge), asynchronous active-low reset
//   irq_src          asynchronous peripheral requests, rising edge = request
//   A, D_in          Z80 address low byte and data from the CPU
//   D_out, D_oe      data to the CPU (vector or register) and its drive enable
//   nM1, nIORQ       Z80 bus strobes, active low
//   nRD, nWR         Z80 bus strobes, active low
//   nINT             interrupt request to the CPU, active low
module z80_int_ctrl #(
    parameter int         NUM_SRC = 8,
    parameter logic [7:0] IO_BASE = 8'h40
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         A,
    input  logic [7:0]         D_in,
    output logic [7:0]         D_out,
    output logic               D_oe,
    input  logic               nM1,
    input  logic               nIORQ,
    input  logic               nRD,
    input  logic               nWR,
    output logic               nINT
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [7:0]         vbase_q, vbase_d;
    logic [2:0]         win_q, win_d;
    logic               spur_q, spur_d;
    logic               wr_seen_q;

    logic [NUM_SRC-1:0] rise, elig, take_oh;
    logic [7:0]         off, rd_data, vector;
    logic               sel, ack_strobe, wr_fire, may_request, take;

    function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign rise       = sync2_q & ~prev_q;
    assign elig       = pend_q & ~mask_q;
    assign off        = A - IO_BASE;
    assign sel        = !nIORQ && nM1 && (off < 8'd4);
    assign ack_strobe = !nM1 && !nIORQ;
    // One write per access: only the first edge with nWR low acts.
    assign wr_fire    = sel && !nWR && !wr_seen_q;
    // One-hot of the winning source, used only on the edge that takes the ack.
    assign take_oh    = take ? (elig & (-elig)) : '0;

`ifdef ICTRL_NEST_EN
    logic [NUM_SRC-1:0] isr_top, hi_mask;
    // hi_mask = every source above the highest-priority one in service;
    // all ones when nothing is in service.
    assign isr_top     = isr_q & (-isr_q);
    assign hi_mask     = isr_top - ONE;
    assign may_request = |(elig & hi_mask);
`else
    assign may_request = (isr_q == '0);
`endif

    assign vector = spur_q ? {vbase_q[7:4], 4'hE} : {vbase_q[7:4], win_q, 1'b0};

    always_comb begin
        rd_data = '0;
        case (off[1:0])
            2'd0:    rd_data = 8'(mask_q);
            2'd1:    rd_data = 8'(pend_q);
            2'd2:    rd_data = vbase_q;
            default: rd_data = 8'(isr_q);
        endcase
    end

    // Bus drive is combinational on the strobes so it drops the moment the CPU
    // releases them (and at once on reset, which forces state to IDLE).
    always_comb begin
        D_oe  = 1'b0;
        D_out = '0;
        if (sel && !nRD) begin
            D_oe  = 1'b1;
            D_out = rd_data;
        end else if (state_q == S_ACK && ack_strobe) begin
            D_oe  = 1'b1;
            D_out = vector;
        end
    end

    assign nINT = (state_q != S_REQ);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        spur_d  = spur_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ack_strobe) begin
                    state_d = S_ACK;
                    spur_d  = 1'b1;
                end else if (|elig && may_request) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_strobe) begin
                    state_d = S_ACK;
                    if (|elig) begin
                        win_d  = lowest_idx(elig);
                        spur_d = 1'b0;
                        take   = 1'b1;
                    end else begin
                        spur_d = 1'b1;
                    end
                end else if (!(|elig)) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                if (!ack_strobe) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        pend_d  = pend_q;
        isr_d   = isr_q;
        vbase_d = vbase_q;
        if (wr_fire) begin
            case (off[1:0])
                2'd0:    mask_d  = D_in[NUM_SRC-1:0];
                2'd1:    pend_d  = pend_q & ~D_in[NUM_SRC-1:0];
                2'd2:    vbase_d = {D_in[7:1], 1'b0};
                // EOI: drop the lowest set bit (highest priority in service).
                default: isr_d   = isr_q & (isr_q - ONE);
            endcase
        end
        pend_d = (pend_d & ~take_oh) | rise;
        isr_d  = isr_d | take_oh;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            mask_q    <= '1;
            pend_q    <= '0;
            isr_q     <= '0;
            vbase_q   <= '0;
            win_q     <= '0;
            spur_q    <= 1'b0;
            wr_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= irq_src;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
            vbase_q   <= vbase_d;
            win_q     <= win_d;
            spur_q    <= spur_d;
            wr_seen_q <= sel && !nWR;
        end
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
module tb_z80_int_ctrl;

    localparam logic [7:0] BASE = 8'h40;

    logic       CLK    = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] irq_src = '0;
    logic [7:0] A = '0;
    logic [7:0] D_in = '0;
    logic [7:0] D_out;
    logic       D_oe;
    logic       nM1 = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1;
    logic       nINT;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    z80_int_ctrl #(.NUM_SRC(8), .IO_BASE(BASE)) dut (
        .CLK(CLK), .nRESET(nRESET), .irq_src(irq_src), .A(A), .D_in(D_in),
        .D_out(D_out), .D_oe(D_oe), .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD),
        .nWR(nWR), .nINT(nINT)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model (spec-level) ----------------
    localparam int M_IDLE = 0, M_REQ = 1, M_ACK = 2;
    logic [7:0] m_pend = '0, m_mask = 8'hFF, m_isr = '0, m_vbase = '0, m_prev = '0;
    logic [7:0] m_sched [4];
    int         m_mode = M_IDLE, m_w = 0, cyc = 0;
    bit         m_spur = 1'b0, m_wrseen = 1'b0;

    function automatic int low_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic bit may_req(input logic [7:0] e, input logic [7:0] isr);
`ifdef ICTRL_NEST_EN
        return (e != 0) && (low_bit(e) < low_bit(isr));
`else
        return (e != 0) && (isr == 0);
`endif
    endfunction

    function automatic int reg_off();
        return int'(A) - int'(BASE);
    endfunction

    function automatic bit bus_sel();
        return !nIORQ && nM1 && reg_off() >= 0 && reg_off() < 4;
    endfunction

    always begin : model
        logic [7:0] e, np, ni;
        bit strobe, wr, take;
        int off;
        @(posedge CLK or negedge nRESET);
        if (!nRESET) begin
            m_pend = '0; m_mask = 8'hFF; m_isr = '0; m_vbase = '0; m_prev = '0;
            m_mode = M_IDLE; m_w = 0; m_spur = 0; m_wrseen = 0; cyc = 0;
            for (int i = 0; i < 4; i++) m_sched[i] = '0;
        end else begin
            e      = m_pend & ~m_mask;
            off    = reg_off();
            strobe = !nM1 && !nIORQ;
            wr     = bus_sel() && !nWR && !m_wrseen;
            m_wrseen = bus_sel() && !nWR;
            take   = 0;
            case (m_mode)
                M_IDLE: if (strobe) begin m_mode = M_ACK; m_spur = 1; end
                        else if (may_req(e, m_isr)) m_mode = M_REQ;
                M_REQ:  if (strobe) begin
                            m_mode = M_ACK;
                            if (e != 0) begin m_w = low_bit(e); m_spur = 0; take = 1; end
                            else m_spur = 1;
                        end else if (e == 0) m_mode = M_IDLE;
                default: if (!strobe) m_mode = M_IDLE;
            endcase
            np = m_pend;
            ni = m_isr;
            if (wr) begin
                case (off)
                    0: m_mask = D_in;
                    1: np = np & ~D_in;
                    2: m_vbase = D_in & 8'hFE;
                    default: if (ni != 0) ni[low_bit(ni)] = 1'b0;
                endcase
            end
            if (take) begin np[m_w] = 1'b0; ni[m_w] = 1'b1; end
            np = np | m_sched[cyc % 4];
            m_sched[cyc % 4] = '0;
            for (int i = 0; i < 8; i++)
                if (irq_src[i] && !m_prev[i]) m_sched[(cyc + 2) % 4][i] = 1'b1;
            m_prev = irq_src;
            m_pend = np;
            m_isr  = ni;
            cyc++;
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of all outputs against the model.
    always begin : compare
        logic [7:0] exp_d;
        bit exp_oe;
        @(negedge CLK);
        if (chk_en) begin
            exp_d = '0;
            exp_oe = 0;
            if (bus_sel() && !nRD) begin
                exp_oe = 1;
                case (reg_off())
                    0: exp_d = m_mask;
                    1: exp_d = m_pend;
                    2: exp_d = m_vbase;
                    default: exp_d = m_isr;
                endcase
            end else if (m_mode == M_ACK && !nM1 && !nIORQ) begin
                exp_oe = 1;
                exp_d  = m_spur ? {m_vbase[7:4], 4'hE} : {m_vbase[7:4], 3'(m_w), 1'b0};
            end
            check("cyc_nINT", 8'(nINT), 8'(m_mode != M_REQ));
            check("cyc_D_oe", 8'(D_oe), 8'(exp_oe));
            check("cyc_D_out", D_out, exp_d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge CLK); #2; end
    endtask

    task automatic io_wr(input int r, input logic [7:0] d);
        A = BASE + 8'(r); D_in = d; nIORQ = 0; nWR = 0;
        tick(2);
        nIORQ = 1; nWR = 1;
        tick();
    endtask

    task automatic io_rd(input int r, input logic [7:0] exp, input bit lit, input string nm);
        A = BASE + 8'(r); nIORQ = 0; nRD = 0;
        #1;
        if (lit) begin
            check(nm, D_out, exp);
            check({nm, "_oe"}, 8'(D_oe), 8'h01);
        end
        tick();
        nIORQ = 1; nRD = 1;
        tick();
    endtask

    task automatic do_ack(input logic [7:0] exp, input bit lit, input string nm);
        nM1 = 0;
        tick();
        nIORQ = 0;
        tick();
        #1;
        if (lit) begin
            check(nm, D_out, exp);
            check({nm, "_oe"}, 8'(D_oe), 8'h01);
        end
        tick();
        nM1 = 1; nIORQ = 1;
        #1;
        check({nm, "_oe_off"}, 8'(D_oe), 8'h00);
        tick();
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_src = m;
        tick();
        irq_src = '0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_sched[i] = '0;
        tick(3);
        nRESET = 1;
        chk_en = 1;
        tick();
        // Reset values
        check("rst_nINT", 8'(nINT), 8'h01);
        check("rst_D_oe", 8'(D_oe), 8'h00);
        io_rd(0, 8'hFF, 1, "rst_MASK");
        io_rd(1, 8'h00, 1, "rst_PEND");
        io_rd(2, 8'h00, 1, "rst_VBASE");
        io_rd(3, 8'h00, 1, "rst_ISR");

        // Single source: request latency and vector
        io_wr(0, 8'h00);
        io_wr(2, 8'h81);
        io_rd(2, 8'h80, 1, "vbase_bit0");
        irq_src = 8'h08;
        tick(4);
        check("t1_nINT_low", 8'(nINT), 8'h00);
        irq_src = '0;
        do_ack(8'h86, 1, "t1_vec");
        check("t1_nINT_high", 8'(nINT), 8'h01);
        io_rd(1, 8'h00, 1, "t1_PEND");
        io_rd(3, 8'h08, 1, "t1_ISR");

`ifndef ICTRL_NEST_EN
        // Two sources at once; one in service blocks further requests
        pulse(8'h22);
        tick(3);
        check("t2_blocked", 8'(nINT), 8'h01);
        io_rd(1, 8'h22, 1, "t2_PEND");
        io_wr(3, 8'h00);
        check("t2_req1", 8'(nINT), 8'h00);
        do_ack(8'h82, 1, "t2_vec1");
        tick(3);
        check("t2_no_eoi", 8'(nINT), 8'h01);
        io_wr(3, 8'h00);
        check("t2_req2", 8'(nINT), 8'h00);
        do_ack(8'h8A, 1, "t2_vec2");
        io_rd(3, 8'h20, 1, "t2_ISR");
        io_wr(3, 8'h00);
        io_rd(3, 8'h00, 1, "t2_ISR_eoi");
`else
        // Nested: higher-priority source preempts the one in service
        io_wr(3, 8'h00);
        pulse(8'h10);
        tick(3);
        do_ack(8'h88, 1, "t6_vec4");
        pulse(8'h04);
        tick(3);
        check("t6_nest_req", 8'(nINT), 8'h00);
        do_ack(8'h84, 1, "t6_vec2");
        io_rd(3, 8'h14, 1, "t6_ISR");
        io_wr(3, 8'h00);
        io_rd(3, 8'h10, 1, "t6_ISR_eoi1");
        io_wr(3, 8'h00);
        io_rd(3, 8'h00, 1, "t6_ISR_eoi2");
`endif

        // Masked source still latches; clearing pending withdraws the request
        io_wr(0, 8'hFF);
        pulse(8'h01);
        tick(3);
        check("t3_masked", 8'(nINT), 8'h01);
        io_rd(1, 8'h01, 1, "t3_PEND");
        io_wr(0, 8'h00);
        check("t3_unmask", 8'(nINT), 8'h00);
        io_wr(1, 8'h01);
        check("t3_w1c", 8'(nINT), 8'h01);
        io_rd(1, 8'h00, 1, "t3_PEND_clr");

        // W1C on the same edge as a new request: set wins
        io_wr(0, 8'hFF);
        irq_src = 8'h04;
        tick();
        irq_src = '0;
        tick();
        io_wr(1, 8'h04);
        io_rd(1, 8'h04, 1, "t4_set_wins");
        io_wr(1, 8'hFF);

        // Asynchronous reset during the acknowledge
        io_wr(0, 8'h00);
        irq_src = 8'h10;
        tick(4);
        irq_src = '0;
        check("t5_req", 8'(nINT), 8'h00);
        nM1 = 0;
        tick();
        nIORQ = 0;
        tick();
        #1;
        check("t5_vec", D_out, 8'h88);
        #1;
        nRESET = 0;
        #1;
        check("t5_rst_oe", 8'(D_oe), 8'h00);
        check("t5_rst_nINT", 8'(nINT), 8'h01);
        tick(2);
        nM1 = 1; nIORQ = 1;
        tick();
        nRESET = 1;
        tick();
        io_rd(0, 8'hFF, 1, "t5_MASK");
        io_rd(1, 8'h00, 1, "t5_PEND");
        io_rd(2, 8'h00, 1, "t5_VBASE");
        io_rd(3, 8'h00, 1, "t5_ISR");

        // Spurious acknowledge
        io_wr(2, 8'h80);
        do_ack(8'h8E, 1, "spur_vec");
        io_rd(1, 8'h00, 1, "spur_PEND");
        io_rd(3, 8'h00, 1, "spur_ISR");

        // Randomized traffic, checked every cycle by the model compare
        io_wr(0, 8'h00);
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: pulse(8'($urandom));
                3:       io_wr(0, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom));
                4:       io_wr(1, 8'($urandom));
                5, 6:    io_wr(3, 8'h00);
                7:       io_wr(2, 8'($urandom));
                8:       io_rd($urandom_range(0, 3), 8'h00, 0, "rnd_rd");
                9, 10:   if (m_mode == M_REQ) do_ack(8'h00, 0, "rnd_ack");
                         else tick($urandom_range(1, 3));
                default: do_ack(8'h00, 0, "rnd_any_ack");
            endcase
        end
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
